// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
//
// Instruction-fetch stage. Owns the PC, drives the instruction-memory read
// address and enable, forwards next-PC through two pipeline slots so EX can
// use it as a branch/JAL source, and runs a BOOT -> RUN -> HALT sequencer.
// Two saturating performance counters track accepted fetches and redirects.
//
// Ports
//   clk                in   1      clock, posedge
//   rst_n              in   1      asynchronous active-low reset
//   stall_IM_ID        in   1      decode stall: hold the PC
//   stall_ID_EX        in   1      hold the pc_ID_EX pipeline flop
//   flow_change_ID_EX  in   1      taken branch/jump from EX: redirect
//   dst_ID_EX          in   PC_W   redirect target (valid with flow change)
//   hlt_DM_WB          in   1      halt retired: freeze until reset
//   cnt_clr            in   1      synchronous clear of both counters
//   iaddr              out  PC_W   instruction-memory read address (= pc)
//   im_rd_en           out  1      instruction-memory read enable
//   pc_ID_EX           out  PC_W   next-PC of the instruction now in EX
//   halted             out  1      high while in HALT
//   fetch_cnt          out  CNT_W  PC advances accepted (saturating)
//   redir_cnt          out  CNT_W  redirects taken (saturating)
// ----------------------------------------------------------------------------
module instr_fetch #(
    parameter int              PC_W   = 16,
    parameter logic [PC_W-1:0] RST_PC = '0,
    parameter int              CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_IM_ID,
    input  logic             stall_ID_EX,
    input  logic             flow_change_ID_EX,
    input  logic [PC_W-1:0]  dst_ID_EX,
    input  logic             hlt_DM_WB,
    input  logic             cnt_clr,
    output logic [PC_W-1:0]  iaddr,
    output logic             im_rd_en,
    output logic [PC_W-1:0]  pc_ID_EX,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] redir_cnt
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [PC_W-1:0]  RST_NPC = RST_PC + PC_ONE;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_IM_ID;
    logic [PC_W-1:0] nxt_pc;

    logic            in_run;
    logic            take_redir;
    logic            take_fetch;
    logic            npc_load;

    // Natural wrap at 2^PC_W comes for free from the fixed-width add.
    assign nxt_pc = pc + PC_ONE;
    assign iaddr  = pc;

    // Halt outranks redirect, and redirect outranks stall, so a redirect is
    // honoured even while decode is stalled.
    assign in_run     = (state == RUN);
    assign take_redir = in_run && !hlt_DM_WB && flow_change_ID_EX;
    assign take_fetch = in_run && !hlt_DM_WB && !flow_change_ID_EX && !stall_IM_ID;

    // The IM->ID next-PC slot follows the fetch; wrong-path slots after a
    // redirect are left for decode to flush.
    assign npc_load = in_run && !stall_IM_ID && !flow_change_ID_EX;

    // Sequencer, PC and next-PC pipeline. im_rd_en and halted are registered
    // so they change on the same edge as the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            pc       <= RST_PC;
            pc_IM_ID <= RST_NPC;
            pc_ID_EX <= RST_NPC;
            im_rd_en <= 1'b0;
            halted   <= 1'b0;
        end else begin
            if (npc_load) begin
                pc_IM_ID <= nxt_pc;
            end
            if (!stall_ID_EX && (state != HALT)) begin
                pc_ID_EX <= pc_IM_ID;
            end

            case (state)
                BOOT: begin
                    state    <= RUN;
                    im_rd_en <= 1'b1;
                end
                RUN: begin
                    if (hlt_DM_WB) begin
                        state    <= HALT;
                        im_rd_en <= 1'b0;
                        halted   <= 1'b1;
                    end else if (flow_change_ID_EX) begin
                        pc <= dst_ID_EX;
                    end else if (!stall_IM_ID) begin
                        pc <= nxt_pc;
                    end
                end
                HALT: begin
                    im_rd_en <= 1'b0;
                    halted   <= 1'b1;
                end
                default: begin
                    state    <= BOOT;
                    im_rd_en <= 1'b0;
                    halted   <= 1'b0;
                end
            endcase
        end
    end

    // Performance counters stick at all-ones instead of wrapping; a clear
    // beats any increment in the same cycle and is honoured in HALT too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= '0;
            redir_cnt <= '0;
        end else if (cnt_clr) begin
            fetch_cnt <= '0;
            redir_cnt <= '0;
        end else begin
            if (take_fetch && (fetch_cnt != CNT_MAX)) begin
                fetch_cnt <= fetch_cnt + CNT_ONE;
            end
            if (take_redir && (redir_cnt != CNT_MAX)) begin
                redir_cnt <= redir_cnt + CNT_ONE;
            end
        end
    end

endmodule
